branch_unit_p: RTL
==================

Name: branch_unit_p

Overview:
- Parametrised successor to the core's branch/jump unit. It lives in the execute stage of the RV32I-family core.
- Evaluates branch conditions internally from funct3 and ALU flags, so no external Cond input is needed.
- Computes branch/jump targets and link values against a configurable-depth PC delay line.
- Generates a redirect pulse plus a multi-cycle flush window that squashes wrong-path instructions already in the pipe.

Parameters:
- XLEN, 32, datapath/PC width in bits (32 or 64).
- PC_DLY, 3, advancing cycles from pc_current (fetch) to the instruction's appearance at decode inputs; legal range 1..8.
- FLUSH_CYC, 2, cycles flush is asserted per redirect, including the redirect cycle; legal range 1..7.

Ports:
- clk  in  1  core clock.
- rstB  in  1  asynchronous active-low reset.
- stall  in  1  pipeline stall; freezes the delay line, the resolve stage and the flush counter.
- b_type  in  1  decode: conditional branch.
- op_jal  in  1  decode: JAL.
- op_jalr  in  1  decode: JALR.
- imm21_j  in  21  JAL byte offset, bit0=0, signed.
- imm13_b  in  13  branch byte offset, bit0=0, signed.
- funct3  in  3  branch condition select.
- alu_result  in  XLEN  ALU sum (JALR base+imm), valid in the resolve cycle.
- alu_zero  in  1  rs1==rs2, valid in the resolve cycle.
- alu_lt  in  1  signed rs1<rs2, valid in the resolve cycle.
- alu_ltu  in  1  unsigned rs1<rs2, valid in the resolve cycle.
- pc_current  in  XLEN  fetch PC.
- pc_return  out  XLEN  link value for the decoding JAL/JALR, else 0.
- pc_jmpto  out  XLEN  next fetch PC.
- redirect  out  1  one-cycle pulse: taken branch or jump resolved.
- flush  out  1  squash wrong-path instructions.
- misalign  out  1  target misaligned trap pulse (only with the optional feature; tied 0 otherwise).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous and active-low on rstB.
  - Reset clears all registers: delay line, resolve registers, flush counter.
  - Post-reset outputs: redirect=0, flush=0, misalign=0, pc_return=0, pc_jmpto=pc_current+4.
  - Reset asserted mid-flush drops flush in the same cycle.
- PC delay line:
  - PC_DLY-entry shift register. Entry 0 loads pc_current; entry k loads entry k-1.
  - Advances only when !stall.
  - Decode PC (dpc) is entry PC_DLY-1.
- Decode cycle T:
  - valid_d = (b_type|op_jal|op_jalr) & !flush.
  - pc_return = dpc+4 when op_jal|op_jalr and not flushed; otherwise 0. Combinational.
- Resolve-stage registers:
  - Loaded at the end of T when !stall: kind {none, B, JAL, JALR}, funct3, dpc, sign-extended imm.
  - imm13_b and imm21_j are already byte offsets. They are sign-extended to XLEN with no extra shift.
  - If valid_d=0, kind loads "none".
  - When stall=1, all resolve registers hold.
- Resolve cycle T+1, combinational:
  - Taken condition by funct3:
    - 000 BEQ: zero.
    - 001 BNE: !zero.
    - 100 BLT: lt.
    - 101 BGE: !lt.
    - 110 BLTU: ltu.
    - 111 BGEU: !ltu.
    - 010/011: never taken.
  - Target:
    - JAL: rpc+rimm.
    - JALR: {alu_result[XLEN-1:1],0}.
    - B taken: rpc+rimm.
    - Adds wrap modulo 2^XLEN.
  - redirect = (JAL|JALR|B-taken) & !stall.
  - pc_jmpto = target when redirect, else pc_current+4.
  - While stalled, resolve state is held; redirect fires in the first unstalled cycle.
- Flush counter (3 bits):
  - Loads FLUSH_CYC-1 on redirect.
  - flush = redirect | (cnt!=0).
  - Decrements only when !stall and cnt!=0.
  - A redirect asserted while cnt!=0 is impossible, because decode is squashed during the flush window.
  - A kind loaded as "none" never redirects.
- Latency:
  - Decode to redirect is 1 cycle, plus any stall cycles.
  - Back-to-back jumps in consecutive decode cycles: the second is squashed by flush.

Optional Feature:
- Macro: BRU_MISALIGN_TRAP_EN.
- Defined:
  - If a taken target has target[1]!=0, misalign pulses for 1 cycle.
  - In that case redirect is suppressed, flush is not started, and pc_jmpto=pc_current+4.
- Undefined:
  - misalign is tied 0.
  - Misaligned targets redirect normally.

Test Plan:
- BEQ taken:
  - Stimulus: PC_DLY=3; pc_current steps 0x100,0x104,... BEQ decoded at dpc=0x100, imm13_b=0x010, alu_zero=1 in T+1.
  - Required: redirect=1 and pc_jmpto=0x110 in T+1; flush high in T+1 and T+2, low in T+3.
- BNE not taken:
  - Stimulus: same setup as above with BNE, alu_zero=1.
  - Required: redirect=0, flush=0, pc_jmpto=pc_current+4.
- JAL backward:
  - Stimulus: JAL at dpc=0x200, imm21_j=0x1FFFF8.
  - Required: pc_return=0x204 in T; redirect=1 and pc_jmpto=0x1F8 in T+1.
- JALR with stall:
  - Stimulus: alu_result=0x00000301; stall=1 in T+1..T+2.
  - Required: redirect=0 while stalled; redirect=1 and pc_jmpto=0x300 in T+3.
- Back-to-back:
  - Stimulus: JAL in T followed by BEQ taken in T+1.
  - Required: BEQ squashed; exactly one redirect; pc_return=0 for the squashed slot.
- Reset and misalign:
  - Stimulus: rstB low during flush.
  - Required: flush=0 immediately.
  - Stimulus: with BRU_MISALIGN_TRAP_EN, JALR alu_result=0x302.
  - Required: misalign=1, redirect=0.

Source files
------------

// File: rtl/branch_unit_p.sv
// Execute-stage branch/jump unit: PC delay line, resolve stage, redirect and flush window.
// Optional target-misalign trap enabled by defining BRU_MISALIGN_TRAP_EN.
module branch_unit_p #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PC_DLY    = 3,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rstB,
    input  logic            stall,
    input  logic            b_type,
    input  logic            op_jal,
    input  logic            op_jalr,
    input  logic [20:0]     imm21_j,
    input  logic [12:0]     imm13_b,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_lt,
    input  logic            alu_ltu,
    input  logic [XLEN-1:0] pc_current,
    output logic [XLEN-1:0] pc_return,
    output logic [XLEN-1:0] pc_jmpto,
    output logic            redirect,
    output logic            flush,
    output logic            misalign
);

    typedef enum logic [1:0] {K_NONE, K_B, K_JAL, K_JALR} kind_e;

    localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
    localparam logic [2:0]      CNT_LOAD = 3'(FLUSH_CYC - 1);

    logic [XLEN-1:0] pc_dly_q [PC_DLY];
    kind_e           kind_q, kind_d;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] rpc_q, rimm_q, rimm_d;
    logic [2:0]      cnt_q, cnt_d;

    logic [XLEN-1:0] dpc;
    logic            is_jump;
    logic            valid_d;
    logic            cond_taken;
    logic            take;
    logic [XLEN-1:0] target;

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            for (int unsigned k = 0; k < PC_DLY; k++) pc_dly_q[k] <= '0;
        end else if (!stall) begin
            pc_dly_q[0] <= pc_current;
            for (int unsigned k = 1; k < PC_DLY; k++) pc_dly_q[k] <= pc_dly_q[k-1];
        end
    end

    // Decode stage: anything arriving inside the flush window is wrong-path.
    always_comb begin
        dpc     = pc_dly_q[PC_DLY-1];
        is_jump = op_jal | op_jalr;
        valid_d = (b_type | is_jump) & ~flush;
        pc_return = (is_jump && !flush) ? dpc + FOUR : '0;
        kind_d = K_NONE;
        if (valid_d) begin
            if (op_jal)       kind_d = K_JAL;
            else if (op_jalr) kind_d = K_JALR;
            else              kind_d = K_B;
        end
        rimm_d = op_jal ? {{(XLEN-21){imm21_j[20]}}, imm21_j}
                        : {{(XLEN-13){imm13_b[12]}}, imm13_b};
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            kind_q   <= K_NONE;
            funct3_q <= '0;
            rpc_q    <= '0;
            rimm_q   <= '0;
        end else if (!stall) begin
            kind_q   <= kind_d;
            funct3_q <= funct3;
            rpc_q    <= dpc;
            rimm_q   <= rimm_d;
        end
    end

    always_comb begin
        case (funct3_q)
            3'b000:  cond_taken = alu_zero;
            3'b001:  cond_taken = ~alu_zero;
            3'b100:  cond_taken = alu_lt;
            3'b101:  cond_taken = ~alu_lt;
            3'b110:  cond_taken = alu_ltu;
            3'b111:  cond_taken = ~alu_ltu;
            default: cond_taken = 1'b0;
        endcase
        take = (kind_q == K_JAL) | (kind_q == K_JALR) | ((kind_q == K_B) & cond_taken);
        target = (kind_q == K_JALR) ? (alu_result & ~XLEN'(1)) : rpc_q + rimm_q;
`ifdef BRU_MISALIGN_TRAP_EN
        misalign = take & target[1] & ~stall;
        redirect = take & ~target[1] & ~stall;
`else
        misalign = 1'b0;
        redirect = take & ~stall;
`endif
        pc_jmpto = redirect ? target : pc_current + FOUR;
        flush    = redirect | (cnt_q != '0);
        cnt_d = cnt_q;
        if (redirect)                   cnt_d = CNT_LOAD;
        else if (!stall && cnt_q != '0) cnt_d = cnt_q - 3'd1;
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule
